// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared states, instruction-class codes and field positions for cpu_cu
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ALU    = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_LDI    = 4'd5,
        S_JMP    = 4'd6,
        S_JCC    = 4'd7,
        S_HALT   = 4'd8,
        S_ERROR  = 4'd9
    } state_t;

    localparam logic [2:0] CLS_ALU   = 3'b000;
    localparam logic [2:0] CLS_LOAD  = 3'b001;
    localparam logic [2:0] CLS_STORE = 3'b010;
    localparam logic [2:0] CLS_LDI   = 3'b011;
    localparam logic [2:0] CLS_JMP   = 3'b100;
    localparam logic [2:0] CLS_JCC   = 3'b101;
    localparam logic [2:0] CLS_HALT  = 3'b110;
    localparam logic [2:0] CLS_ILL   = 3'b111;

    localparam int CLS_MSB  = 11;
    localparam int CLS_LSB  = 9;
    localparam int MASK_MSB = 8;
    localparam int MASK_LSB = 6;

    // States that wait on mem_rdy and are therefore guarded by the timeout.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_LOAD) || (s == S_STORE) || (s == S_LDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_cu_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_cu_timer : memory-access timeout counter; expired flags the wait cycle
//                in which the count reaches MEM_TIMEOUT.
// Rev 1.0
// ----------------------------------------------------------------------------
module cpu_cu_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TW          = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TW-1:0] C_LAST = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires in the wait cycle whose increment brings the count to MEM_TIMEOUT.
    assign expired = inc && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_cu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_cu : fetch/decode/execute control FSM driving the EU strobes and memory
//          handshake. CPU_CU_ILLEGAL_TRAP_EN makes class 111 trap to ERROR.
// Rev 1.0
// ----------------------------------------------------------------------------
module cpu_cu
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TW          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        c,
    input  logic        mem_rdy,
    output logic        adr_sel,
    output logic        s_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        reg_w_en,
    output logic        ir_ld,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        retire,
    output logic        halted,
    output logic        error
);

    state_t     r_state;
    state_t     w_next;
    logic       r_halt_seen;
    logic       w_clr;
    logic       w_inc;
    logic       w_expired;
    logic [2:0] w_cls;
    logic       w_taken;
    logic       w_unused_ir;

    assign w_cls       = ir[CLS_MSB:CLS_LSB];
    assign w_taken     = |(ir[MASK_MSB:MASK_LSB] & {n, z, c});
    assign w_unused_ir = &{1'b0, ir[15:12], ir[5:0]};

    // Every state change restarts the count, so each memory state starts at zero.
    assign w_inc = is_mem_state(r_state) && !mem_rdy;
    assign w_clr = (w_next != r_state);

    cpu_cu_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TW          (TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_clr),
        .inc     (w_inc),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_halt_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_HALT) begin
                r_halt_seen <= 1'b1;
            end
        end
    end

    // Outputs are gated by reset so a pending request drops asynchronously.
    always_comb begin
        w_next   = r_state;
        adr_sel  = 1'b0;
        s_sel    = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        reg_w_en = 1'b0;
        ir_ld    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        error    = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_rdy) begin
                        ir_ld  = 1'b1;
                        pc_inc = 1'b1;
                        w_next = S_DECODE;
                    end else if (w_expired) begin
                        w_next = S_ERROR;
                    end
                end
                S_DECODE: begin
                    case (w_cls)
                        CLS_ALU:   w_next = S_ALU;
                        CLS_LOAD:  w_next = S_LOAD;
                        CLS_STORE: w_next = S_STORE;
                        CLS_LDI:   w_next = S_LDI;
                        CLS_JMP:   w_next = S_JMP;
                        CLS_JCC:   w_next = S_JCC;
                        CLS_HALT:  w_next = S_HALT;
                        default: begin
`ifdef CPU_CU_ILLEGAL_TRAP_EN
                            w_next = S_ERROR;
`else
                            retire = 1'b1;
                            w_next = S_FETCH;
`endif
                        end
                    endcase
                end
                S_ALU: begin
                    reg_w_en = 1'b1;
                    retire   = 1'b1;
                    w_next   = S_FETCH;
                end
                S_LOAD: begin
                    adr_sel = 1'b1;
                    mem_rd  = 1'b1;
                    if (mem_rdy) begin
                        s_sel    = 1'b1;
                        reg_w_en = 1'b1;
                        retire   = 1'b1;
                        w_next   = S_FETCH;
                    end else if (w_expired) begin
                        w_next = S_ERROR;
                    end
                end
                S_STORE: begin
                    adr_sel = 1'b1;
                    mem_wr  = 1'b1;
                    if (mem_rdy) begin
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end else if (w_expired) begin
                        w_next = S_ERROR;
                    end
                end
                S_LDI: begin
                    mem_rd = 1'b1;
                    if (mem_rdy) begin
                        s_sel    = 1'b1;
                        reg_w_en = 1'b1;
                        pc_inc   = 1'b1;
                        retire   = 1'b1;
                        w_next   = S_FETCH;
                    end else if (w_expired) begin
                        w_next = S_ERROR;
                    end
                end
                S_JMP: begin
                    pc_ld  = 1'b1;
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
                S_JCC: begin
                    pc_ld  = w_taken;
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                    retire = !r_halt_seen;
                end
                S_ERROR: begin
                    halted = 1'b1;
`ifdef CPU_CU_ILLEGAL_TRAP_EN
                    error  = 1'b1;
`endif
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_cu.md
Name: cpu_cu

Overview:
- Control unit FSM for the 16-bit CPU. It is the counterpart of the execution unit: it consumes the instruction word and the n/z/c flags, and drives the EU control strobes (adr_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld) plus the memory read/write handshake.
- Sequence per instruction: fetch, decode, execute.
- Sits beside the EU inside the CPU top level.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_rdy on any memory access before entering ERROR. Legal range 1..65535.
- TW, 16: width of the timeout counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ir  in  16  instruction register contents from the EU.
- n  in  1  EU negative flag.
- z  in  1  EU zero flag.
- c  in  1  EU carry flag.
- mem_rdy  in  1  memory completes the current access this cycle.
- adr_sel  out  1  0 selects PC as address; 1 selects register output.
- s_sel  out  1  1 selects din as register write source; 0 selects ALU.
- pc_ld  out  1  load PC from ALU output.
- pc_inc  out  1  increment PC.
- reg_w_en  out  1  register file write enable.
- ir_ld  out  1  load IR from din.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  level; high in HALT or ERROR.
- error  out  1  level; high in ERROR only.

Behaviour:
- Instruction class is ir[11:9]:
  - 000 ALU
  - 001 LOAD
  - 010 STORE
  - 011 LDI
  - 100 JMP
  - 101 JCC
  - 110 HALT
  - 111 illegal
- ir[15:12] is the ALU op and passes straight to the EU; the CU ignores it.
- States: FETCH, DECODE, ALU, LOAD, STORE, LDI, JMP, JCC, HALT, ERROR.
- Outputs are decoded combinationally from the state and mem_rdy. Any strobe not listed for a state is 0.
- While reset=0: state=FETCH, timeout counter=0, all outputs 0.
- FETCH: adr_sel=0, mem_rd=1.
  - When mem_rdy=1: ir_ld=1, pc_inc=1 in that same cycle, then go to DECODE.
- DECODE: one cycle, no strobes. Branch on ir[11:9]. Class 111 goes to ERROR.
- ALU: reg_w_en=1, s_sel=0, retire=1, then FETCH. Latency is 1 cycle.
- LOAD: adr_sel=1, mem_rd=1.
  - When mem_rdy=1: s_sel=1, reg_w_en=1, retire=1, then FETCH.
- STORE: adr_sel=1, mem_wr=1 held until mem_rdy=1, then retire=1 and FETCH. Write data is the EU ALU output.
- LDI: adr_sel=0, mem_rd=1.
  - When mem_rdy=1: s_sel=1, reg_w_en=1, pc_inc=1, retire=1, then FETCH.
- JMP: pc_ld=1, retire=1, then FETCH.
- JCC: the branch is taken if (ir[8:6] & {n,z,c}) != 0.
  - Taken: pc_ld=1.
  - Mask 000: never taken.
  - Either way retire=1, then FETCH.
- HALT: retire pulses once on entry. The FSM stays in HALT until reset; halted=1.
- ERROR: halted=1, error=1. The FSM stays in ERROR until reset.
- Timeout counter:
  - Cleared on entry to any memory state (FETCH, LOAD, STORE, LDI).
  - Increments each cycle that mem_rdy=0.
  - When it reaches MEM_TIMEOUT with mem_rdy still 0, go to ERROR; mem_rd/mem_wr drop the next cycle.
  - If mem_rdy and the timeout occur in the same cycle, mem_rdy wins.
- At most one of mem_rd/mem_wr is high in any cycle. pc_ld and pc_inc are never high together.
- Reset asserted mid-access: the request drops immediately (asynchronously). After release, the first cycle is FETCH with the current PC.

Optional Feature:
- Macro: CPU_CU_ILLEGAL_TRAP_EN.
- Defined: class 111 goes to ERROR (as above).
- Not defined: class 111 executes as a NOP. DECODE goes to FETCH with retire=1, and error is tied to 0.

Decomposition:
- Package cpu_pkg holds:
  - the state enum;
  - class codes CLS_ALU..CLS_ILL;
  - field position constants: CLS_MSB/LSB 11/9, MASK_MSB/LSB 8/6.
- One sub-module, cpu_cu_timer: loadable timeout counter with inputs clr and inc, and output expired at MEM_TIMEOUT.

Test Plan:
- Reset low for 3 cycles, then release with mem_rdy=1 -> cycle 1 after release: mem_rd=1, ir_ld=1, pc_inc=1; cycle 2: DECODE, all strobes 0.
- ir=16'h0000 (ALU), mem_rdy=1 -> FETCH, DECODE, ALU cycle with reg_w_en=1, s_sel=0, retire=1; 3 cycles per instruction.
- ir=16'h0200 (LOAD) with mem_rdy held low for 4 cycles -> adr_sel=1 and mem_rd=1 held for 4 cycles; on cycle 5, reg_w_en=1, s_sel=1, retire=1.
- ir=16'h0A40 (JCC, mask 001) with c=1 -> pc_ld=1; with c=0 -> pc_ld=0. retire=1 in both cases.
- MEM_TIMEOUT=8, mem_rdy stuck at 0 in FETCH -> after 8 wait cycles, halted=1 and error=1, mem_rd=0 thereafter; reset recovers to FETCH.
- ir=16'h0E00 with the macro defined -> ERROR state, error=1. Without the macro -> retire=1, returns to FETCH, error=0.
